sseg_scan: RTL and testbench

//  Time-multiplexed driver for a 4-digit common-anode seven-segment display.

---
 rtl/sseg_scan_if.sv | 25 ++
 rtl/sseg_scan.sv | 124 ++++++++++++
 tb/tb_sseg_scan.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sseg_scan_if.sv
// Bus between a BCD source and the seven-segment scan driver: digit/control
// inputs towards the driver, active-low display lines back out.
interface sseg_scan_if;
  logic       en;
  logic       load;
  logic [3:0] bcd3;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic [3:0] dp_mask;
  logic       lz_blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output en, load, bcd3, bcd2, bcd1, bcd0, dp_mask, lz_blank,
    input  an, seg, dp
  );

  modport slave (
    input  en, load, bcd3, bcd2, bcd1, bcd0, dp_mask, lz_blank,
    output an, seg, dp
  );
endinterface

// File: rtl/sseg_scan.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with shadow
// registers, an anti-ghosting dark gap per slot and leading-zero blanking.
module sseg_scan #(
  parameter int REFRESH_DIV = 100_000,
  parameter int GAP_CYCLES  = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  sseg_scan_if.slave  bus
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic {GAP, SHOW} phase_t;

  phase_t          state, state_nxt;
  logic [CW-1:0]   slot_cnt, slot_cnt_nxt, cnt_inc;
  logic [1:0]      digit, digit_nxt;

  logic [3:0][3:0] shadow;
  logic [3:0]      dp_sh;
  logic            lz_sh;
  logic [3:0]      blank;

  logic [3:0]      an_d, an_q;
  logic [6:0]      seg_d, seg_q;
  logic            dp_d, dp_q;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GAP;
      slot_cnt <= '0;
      digit    <= 2'd0;
    end else begin
      state    <= state_nxt;
      slot_cnt <= slot_cnt_nxt;
      digit    <= digit_nxt;
    end
  end

  // state always mirrors whether slot_cnt sits inside the dark gap
  always_comb begin
    cnt_inc      = slot_cnt + CW'(1);
    state_nxt    = state;
    slot_cnt_nxt = slot_cnt;
    digit_nxt    = digit;
    if (!bus.en) begin
      state_nxt    = GAP;
      slot_cnt_nxt = '0;
      digit_nxt    = 2'd0;
    end else if (slot_cnt == CW'(REFRESH_DIV - 1)) begin
      state_nxt    = GAP;
      slot_cnt_nxt = '0;
      digit_nxt    = digit + 2'd1;
    end else begin
      slot_cnt_nxt = cnt_inc;
      state_nxt    = (cnt_inc < CW'(GAP_CYCLES)) ? GAP : SHOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      dp_sh  <= 4'd0;
      lz_sh  <= 1'b0;
    end else if (bus.load) begin
      shadow <= {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
      dp_sh  <= bus.dp_mask;
      lz_sh  <= bus.lz_blank;
    end
  end

  // A digit is a leading zero only if it and everything above it is zero with no point lit
  always_comb begin
    blank    = 4'd0;
    blank[3] = lz_sh && (shadow[3] == 4'd0) && !dp_sh[3];
    blank[2] = blank[3] && (shadow[2] == 4'd0) && !dp_sh[2];
    blank[1] = blank[2] && (shadow[1] == 4'd0) && !dp_sh[1];
  end

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (bus.en && (state == SHOW) && !blank[digit]) begin
      an_d  = ~(4'b0001 << digit);
      seg_d = decode(shadow[digit]);
      dp_d  = ~dp_sh[digit];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 4'b1111;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan with an 8-cycle slot and 2-cycle dark gap;
// outputs are packed as {an, seg, dp} and compared against hand-derived values.
module tb_sseg_scan;

  localparam logic [11:0] DARK = 12'hFFF;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   misses  = 0;

  sseg_scan_if bus();

  sseg_scan #(
    .REFRESH_DIV(8),
    .GAP_CYCLES (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] lit(input logic [3:0] a, input logic [6:0] s, input logic d);
    return {a, s, d};
  endfunction

  function automatic logic [11:0] outs();
    return {bus.an, bus.seg, bus.dp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    vectors++;
    if (observed !== expected) begin
      misses++;
      $display("[TB] FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               tag, observed[11:8], observed[7:1], observed[0],
               expected[11:8], expected[7:1], expected[0]);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic l,
                               input logic [3:0] b3, input logic [3:0] b2,
                               input logic [3:0] b1, input logic [3:0] b0,
                               input logic [3:0] dpm, input logic lz);
    bus.en       = e;
    bus.load     = l;
    bus.bcd3     = b3;
    bus.bcd2     = b2;
    bus.bcd1     = b1;
    bus.bcd0     = b0;
    bus.dp_mask  = dpm;
    bus.lz_blank = lz;
  endtask

  // load with en low so the next scan starts cleanly at the digit 0 gap
  task automatic restart(input string tag,
                         input logic [3:0] b3, input logic [3:0] b2,
                         input logic [3:0] b1, input logic [3:0] b0,
                         input logic [3:0] dpm, input logic lz);
    applyStimulus(1'b0, 1'b1, b3, b2, b1, b0, dpm, lz);
    tick();
    checkOutput({tag, " en0"}, outs(), DARK);
    bus.load = 1'b0;
    bus.en   = 1'b1;
  endtask

  task automatic checkScan(input string tag,
                           input logic [11:0] e0, input logic [11:0] e1,
                           input logic [11:0] e2, input logic [11:0] e3,
                           input int passes);
    logic [11:0] show [4];
    show[0] = e0;
    show[1] = e1;
    show[2] = e2;
    show[3] = e3;
    for (int p = 0; p < passes; p++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 8; c++) begin
          tick();
          checkOutput($sformatf("%s p%0d d%0d c%0d", tag, p, d, c), outs(),
                      (c < 2) ? DARK : show[d]);
        end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    #12;
    checkOutput("reset held", outs(), DARK);
    tick();
    tick();
    checkOutput("reset held clocked", outs(), DARK);

    // release into a zeroed display: digit 0 shows '0' after the 2-cycle gap
    rst_n  = 1'b1;
    bus.en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput($sformatf("post reset c%0d", c), outs(),
                  (c < 2) ? DARK : lit(4'b1110, 7'b1000000, 1'b1));
    end

    // en dropped mid-slot of digit 1
    for (int c = 0; c < 4; c++) tick();
    checkOutput("digit1 before en drop", outs(), lit(4'b1101, 7'b1000000, 1'b1));
    bus.en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("en low c%0d", c), outs(), DARK);
    end
    bus.en = 1'b1;
    tick();
    checkOutput("en back gap0", outs(), DARK);
    tick();
    checkOutput("en back gap1", outs(), DARK);
    tick();
    checkOutput("en back show", outs(), lit(4'b1110, 7'b1000000, 1'b1));

    restart("t2", 4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    checkScan("t2",
              lit(4'b1110, 7'b0011001, 1'b1), lit(4'b1101, 7'b0110000, 1'b1),
              lit(4'b1011, 7'b0100100, 1'b1), lit(4'b0111, 7'b1111001, 1'b1), 2);

    restart("t3a", 4'd0, 4'd0, 4'd4, 4'd2, 4'b0000, 1'b1);
    checkScan("t3a",
              lit(4'b1110, 7'b0100100, 1'b1), lit(4'b1101, 7'b0011001, 1'b1),
              DARK, DARK, 1);

    restart("t3b", 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
    checkScan("t3b", lit(4'b1110, 7'b1000000, 1'b1), DARK, DARK, DARK, 1);

    restart("t4", 4'd0, 4'd0, 4'd0, 4'd5, 4'b0100, 1'b1);
    checkScan("t4",
              lit(4'b1110, 7'b0010010, 1'b1), lit(4'b1101, 7'b1000000, 1'b1),
              lit(4'b1011, 7'b1000000, 1'b0), DARK, 1);

    restart("t5", 4'd0, 4'd0, 4'd0, 4'hC, 4'b0000, 1'b1);
    checkScan("t5", lit(4'b1110, 7'b0111111, 1'b1), DARK, DARK, DARK, 1);

    restart("mix", 4'd8, 4'd9, 4'd6, 4'd7, 4'b1001, 1'b0);
    checkScan("mix",
              lit(4'b1110, 7'b1111000, 1'b0), lit(4'b1101, 7'b0000010, 1'b1),
              lit(4'b1011, 7'b0010000, 1'b1), lit(4'b0111, 7'b0000000, 1'b0), 1);

    // a non-decimal top digit counts as non-zero, so the zeros below it stay lit
    restart("dash top", 4'hA, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
    checkScan("dash top",
              lit(4'b1110, 7'b1000000, 1'b1), lit(4'b1101, 7'b1000000, 1'b1),
              lit(4'b1011, 7'b1000000, 1'b1), lit(4'b0111, 7'b0111111, 1'b1), 1);

    // load mid-SHOW takes effect one cycle later without waiting for the slot end
    restart("midload", 4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    for (int c = 0; c < 4; c++) tick();
    checkOutput("midload before", outs(), lit(4'b1110, 7'b0011001, 1'b1));
    applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd7, 4'b0000, 1'b0);
    tick();
    checkOutput("midload edge", outs(), lit(4'b1110, 7'b0011001, 1'b1));
    bus.load = 1'b0;
    tick();
    checkOutput("midload after", outs(), lit(4'b1110, 7'b1111000, 1'b1));

    // asynchronous reset mid-SHOW, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", outs(), DARK);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("reset restart gap0", outs(), DARK);
    tick();
    checkOutput("reset restart gap1", outs(), DARK);
    tick();
    checkOutput("reset restart show", outs(), lit(4'b1110, 7'b1000000, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
